// File: rtl/sram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sram_pkg                                                         |
// | Purpose  : Shared types and defaults for the asynchronous SRAM controller. |
// |            Holds the controller state enum, the default read/write wait    |
// |            state counts and the width of the wait-state counter.           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package sram_pkg;

  localparam int C_RD_WAIT_DEF = 2;   // oe_n low cycles before read data is sampled
  localparam int C_WR_WAIT_DEF = 1;   // we_n low cycles per write
  localparam int C_WAIT_W      = 4;   // wait counter width, covers 1..15

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_WSETUP = 3'd2,
    ST_WPULSE = 3'd3,
    ST_WHOLD  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sram_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sram_ctrl_if                                                     |
// | Purpose  : CPU-side word port of the SRAM controller.                      |
// |            master : the CPU (drives requests, receives data/ready)         |
// |            slave  : the controller                                         |
// |            cpu_re/cpu_we  - read/write request, held until cpu_ready       |
// |            cpu_addr[29:0] - word address                                   |
// |            cpu_wdata/cpu_be - write data and byte enables                  |
// |            cpu_rdata      - registered read data                           |
// |            cpu_ready      - one-cycle completion pulse                     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface sram_ctrl_if;

  logic        cpu_re;
  logic        cpu_we;
  logic [29:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;

  modport master (
    output cpu_re, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    input  cpu_rdata, cpu_ready
  );

  modport slave (
    input  cpu_re, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    output cpu_rdata, cpu_ready
  );

endinterface
`default_nettype wire

// File: rtl/sram_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sram_ctrl                                                        |
// | Purpose  : Sequences two 256Kx16 asynchronous SRAMs as one 32-bit memory.  |
// |            One word read or write at a time, programmable wait states,     |
// |            owns the bidirectional data bus (driven only in write phases).  |
// | Ports    : clk, rst_n (async, active-low)                                  |
// |            cpu        - sram_ctrl_if.slave request/response port           |
// |            busy       - high in any non-IDLE state                         |
// |            sram_addr  - word address to both chips                         |
// |            sram_dq    - [15:0] low chip, [31:16] high chip                 |
// |            sram_ce_n/oe_n/we_n - shared active-low strobes                 |
// |            sram_lb_n/ub_n[1:0] - byte lanes, index 0 = low chip            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int AWIDTH  = 18,
  parameter int RD_WAIT = C_RD_WAIT_DEF,
  parameter int WR_WAIT = C_WR_WAIT_DEF
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  sram_ctrl_if.slave             cpu,
  output logic                   busy,
  output logic [AWIDTH-1:0]      sram_addr,
  inout  wire  [31:0]            sram_dq,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_we_n,
  output logic [1:0]             sram_lb_n,
  output logic [1:0]             sram_ub_n
);

  // The counter counts down to zero, so a load of N-1 gives N cycles in-state.
  localparam logic [C_WAIT_W-1:0] C_RD_LOAD = C_WAIT_W'(RD_WAIT - 1);
  localparam logic [C_WAIT_W-1:0] C_WR_LOAD = C_WAIT_W'(WR_WAIT - 1);

  state_t                r_state;
  logic [C_WAIT_W-1:0]   r_wait;
  logic [31:0]           r_wdata;
  logic                  r_drive;
  logic                  r_ready;
  logic [31:0]           r_rdata;

  // Bus is released as soon as r_drive drops, including asynchronously on reset.
  assign sram_dq       = r_drive ? r_wdata : 'z;
  assign cpu.cpu_ready = r_ready;
  assign cpu.cpu_rdata = r_rdata;
  assign busy          = (r_state != ST_IDLE);

  // Address bits above the SRAM address width are intentionally ignored.
  if (AWIDTH < 30) begin : g_addr_trim
    wire w_unused_addr = ^cpu.cpu_addr[29:AWIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_wait    <= '0;
      r_wdata   <= '0;
      r_drive   <= 1'b0;
      r_ready   <= 1'b0;
      r_rdata   <= '0;
      sram_addr <= '0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_lb_n <= 2'b11;
      sram_ub_n <= 2'b11;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cpu.cpu_we) begin
            // Write wins over a simultaneous read request.
            sram_addr <= cpu.cpu_addr[AWIDTH-1:0];
            r_wdata   <= cpu.cpu_wdata;
            r_drive   <= 1'b1;
            sram_ce_n <= 1'b0;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            {sram_ub_n[1], sram_lb_n[1], sram_ub_n[0], sram_lb_n[0]} <= ~cpu.cpu_be;
            r_state   <= ST_WSETUP;
          end else if (cpu.cpu_re) begin
            sram_addr <= cpu.cpu_addr[AWIDTH-1:0];
            sram_ce_n <= 1'b0;
            sram_oe_n <= 1'b0;
            sram_lb_n <= 2'b00;
            sram_ub_n <= 2'b00;
            r_wait    <= C_RD_LOAD;
            r_state   <= ST_READ;
          end
        end
        ST_READ: begin
          if (r_wait == '0) begin
            r_rdata   <= sram_dq;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_lb_n <= 2'b11;
            sram_ub_n <= 2'b11;
            r_ready   <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            r_wait <= r_wait - 1'b1;
          end
        end
        ST_WSETUP: begin
          sram_we_n <= 1'b0;
          r_wait    <= C_WR_LOAD;
          r_state   <= ST_WPULSE;
        end
        ST_WPULSE: begin
          if (r_wait == '0) begin
            sram_we_n <= 1'b1;
            r_state   <= ST_WHOLD;
          end else begin
            r_wait <= r_wait - 1'b1;
          end
        end
        ST_WHOLD: begin
          // Address, lanes and data stay put through this cycle for hold time.
          sram_ce_n <= 1'b1;
          sram_lb_n <= 2'b11;
          sram_ub_n <= 2'b11;
          r_drive   <= 1'b0;
          r_ready   <= 1'b1;
          r_state   <= ST_DONE;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sram_ctrl                                                     |
// | Purpose  : Self-checking bench for sram_ctrl. Two controllers (default     |
// |            wait states and RD_WAIT=4/WR_WAIT=3) each talk to a behavioural |
// |            pair of x16 SRAMs; results are compared to a word-level         |
// |            reference memory with byte-enable merging.                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_sram_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // CPU-side stimulus, one slot per controller instance
  logic        re    [2];
  logic        we    [2];
  logic [29:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  be    [2];

  wire  [31:0] rdata  [2];
  wire         ready  [2];
  wire         busy   [2];
  wire  [17:0] saddr  [2];
  wire  [31:0] dq_obs [2];
  wire         ce_n   [2];
  wire         oe_n   [2];
  wire         we_n   [2];
  wire  [1:0]  lb_n   [2];
  wire  [1:0]  ub_n   [2];

  // Reference model: expected word contents, which words are fully known,
  // and the last value a read should have returned.
  logic [31:0] ref_mem [2][256];
  bit          known   [2][256];
  logic [31:0] last_rd [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int RW = (gi == 0) ? 2 : 4;
    localparam int WW = (gi == 0) ? 1 : 3;

    sram_ctrl_if bus ();
    wire [31:0]  dq;
    logic [31:0] mem [256];
    wire         rd_en;

    assign bus.cpu_re    = re[gi];
    assign bus.cpu_we    = we[gi];
    assign bus.cpu_addr  = addr[gi];
    assign bus.cpu_wdata = wdata[gi];
    assign bus.cpu_be    = be[gi];
    assign rdata[gi]     = bus.cpu_rdata;
    assign ready[gi]     = bus.cpu_ready;

    sram_ctrl #(.AWIDTH(18), .RD_WAIT(RW), .WR_WAIT(WW)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu       (bus.slave),
      .busy      (busy[gi]),
      .sram_addr (saddr[gi]),
      .sram_dq   (dq),
      .sram_ce_n (ce_n[gi]),
      .sram_oe_n (oe_n[gi]),
      .sram_we_n (we_n[gi]),
      .sram_lb_n (lb_n[gi]),
      .sram_ub_n (ub_n[gi])
    );

    // Behavioural SRAM pair: low chip on [15:0], high chip on [31:16].
    assign rd_en     = !ce_n[gi] && !oe_n[gi] && we_n[gi];
    assign dq[7:0]   = (rd_en && !lb_n[gi][0]) ? mem[saddr[gi][7:0]][7:0]   : 8'bz;
    assign dq[15:8]  = (rd_en && !ub_n[gi][0]) ? mem[saddr[gi][7:0]][15:8]  : 8'bz;
    assign dq[23:16] = (rd_en && !lb_n[gi][1]) ? mem[saddr[gi][7:0]][23:16] : 8'bz;
    assign dq[31:24] = (rd_en && !ub_n[gi][1]) ? mem[saddr[gi][7:0]][31:24] : 8'bz;

    // Pull-ups make a released bus read back as all ones.
    for (genvar b = 0; b < 32; b++) begin : g_pu
      pullup pu (dq[b]);
    end
    assign dq_obs[gi] = dq;

    always @(posedge clk) begin
      if (!ce_n[gi] && !we_n[gi]) begin
        if (!lb_n[gi][0]) mem[saddr[gi][7:0]][7:0]   <= dq[7:0];
        if (!ub_n[gi][0]) mem[saddr[gi][7:0]][15:8]  <= dq[15:8];
        if (!lb_n[gi][1]) mem[saddr[gi][7:0]][23:16] <= dq[23:16];
        if (!ub_n[gi][1]) mem[saddr[gi][7:0]][31:24] <= dq[31:24];
      end
    end
  end

  function automatic int rd_wait_of(input int k);
    return (k == 0) ? 2 : 4;
  endfunction

  function automatic int wr_wait_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] b);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (b[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Bus-turnaround watch: the controller may only drive dq after oe_n has
  // been high for two full cycles, and oe_n/we_n are never both low.
  int oe_hi [2] = '{100, 100};
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (oe_n[k] === 1'b0) oe_hi[k] <= 0;
      else if (oe_hi[k] < 100) oe_hi[k] <= oe_hi[k] + 1;
      if (rst_n && oe_n[k] && dq_obs[k] !== 32'hFFFF_FFFF) begin
        n_vec++;
        assert (oe_hi[k] >= 2) else begin
          n_err++;
          $error("FAIL turnaround[%0d]: observed %0d cycles oe_n high, expected >= 2", k, oe_hi[k]);
        end
      end
      if (rst_n && !oe_n[k]) begin
        n_vec++;
        assert (we_n[k] === 1'b1) else begin
          n_err++;
          $error("FAIL oe_we_overlap[%0d]: observed we_n %0b, expected 1", k, we_n[k]);
        end
      end
    end
  end

  // Each operation is entered at a negedge. If the controller is still in its
  // DONE cycle, one more cycle passes before IDLE samples the request.
  task automatic write_op(input int k, input logic [29:0] a, input logic [31:0] d,
                          input logic [3:0] b, input logic also_re, input string tag);
    int lat = 0;
    int we_low = 0;
    bit saw_oe = 0;
    addr[k] = a; wdata[k] = d; be[k] = b; we[k] = 1'b1; re[k] = also_re;
    if (busy[k]) @(negedge clk);
    do begin
      @(negedge clk);
      lat++;
      if (!oe_n[k]) saw_oe = 1;
      if (!we_n[k]) begin
        we_low++;
        chk({tag, "_addr"}, saddr[k], a[17:0]);
        chk({tag, "_lb"},   lb_n[k], {~b[2], ~b[0]});
        chk({tag, "_ub"},   ub_n[k], {~b[3], ~b[1]});
        chk({tag, "_dq"},   dq_obs[k], d);
      end
    end while (!ready[k] && lat < 40);
    we[k] = 1'b0; re[k] = 1'b0;
    chk({tag, "_lat"},   lat, wr_wait_of(k) + 3);
    chk({tag, "_welow"}, we_low, wr_wait_of(k));
    chk({tag, "_nooe"},  saw_oe, 0);
    chk({tag, "_rdhold"}, rdata[k], last_rd[k]);
    ref_mem[k][a[7:0]] = merge(ref_mem[k][a[7:0]], d, b);
    if (b == 4'hF) known[k][a[7:0]] = 1;
  endtask

  task automatic read_op(input int k, input logic [29:0] a, input string tag);
    int lat = 0;
    int oe_cyc = 0;
    bit saw_we = 0;
    addr[k] = a; re[k] = 1'b1; we[k] = 1'b0;
    if (busy[k]) @(negedge clk);
    do begin
      @(negedge clk);
      lat++;
      if (!we_n[k]) saw_we = 1;
      if (!oe_n[k]) begin
        oe_cyc++;
        chk({tag, "_addr"}, saddr[k], a[17:0]);
        chk({tag, "_lanes"}, {lb_n[k], ub_n[k]}, 4'b0000);
      end
    end while (!ready[k] && lat < 40);
    re[k] = 1'b0;
    chk({tag, "_lat"},  lat, rd_wait_of(k) + 1);
    chk({tag, "_oe"},   oe_cyc, rd_wait_of(k));
    chk({tag, "_nowe"}, saw_we, 0);
    if (known[k][a[7:0]]) begin
      chk({tag, "_data"}, rdata[k], ref_mem[k][a[7:0]]);
      last_rd[k] = ref_mem[k][a[7:0]];
    end
  endtask

  task automatic idle_check(input int k, input string tag);
    @(negedge clk);
    chk({tag, "_ready"}, ready[k], 0);
    chk({tag, "_busy"},  busy[k], 0);
  endtask

  initial begin
    logic [29:0] a;
    logic [31:0] d;
    for (int k = 0; k < 2; k++) begin
      re[k] = 0; we[k] = 0; addr[k] = '0; wdata[k] = '0; be[k] = '0; last_rd[k] = '0;
      for (int i = 0; i < 256; i++) begin
        ref_mem[k][i] = '0;
        known[k][i]   = 0;
      end
    end

    // Reset state
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_ce",    ce_n[k], 1);
      chk("rst_oe",    oe_n[k], 1);
      chk("rst_we",    we_n[k], 1);
      chk("rst_lanes", {lb_n[k], ub_n[k]}, 4'hF);
      chk("rst_addr",  saddr[k], 0);
      chk("rst_dq",    dq_obs[k], 32'hFFFF_FFFF);
      chk("rst_ready", ready[k], 0);
      chk("rst_rdata", rdata[k], 0);
      chk("rst_busy",  busy[k], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Full write then read back
    write_op(0, 30'h10, 32'hDEAD_BEEF, 4'hF, 0, "wr_dead");
    read_op(0, 30'h10, "rd_dead");
    chk("rd_dead_val", rdata[0], 32'hDEAD_BEEF);

    // Single-lane write: only lb_n[1] low during the pulse
    write_op(0, 30'h3, 32'h1122_3344, 4'hF, 0, "wr_base");
    write_op(0, 30'h3, 32'h00AB_0000, 4'b0100, 0, "wr_lane2");
    read_op(0, 30'h3, "rd_lane2");
    chk("rd_lane2_val", rdata[0], 32'h11AB_3344);

    // Simultaneous re/we performs a write
    write_op(0, 30'h5, 32'hCAFE_F00D, 4'hF, 1, "wr_both");
    read_op(0, 30'h5, "rd_both");
    chk("rd_both_val", rdata[0], 32'hCAFE_F00D);

    // All byte enables low changes nothing but still completes
    write_op(0, 30'h5, 32'h0000_0000, 4'h0, 0, "wr_be0");
    read_op(0, 30'h5, "rd_be0");
    chk("rd_be0_val", rdata[0], 32'hCAFE_F00D);

    // Read immediately followed by a write (turnaround watched continuously)
    read_op(0, 30'h3, "rd_turn");
    write_op(0, 30'h6, 32'h0BAD_F00D, 4'hF, 0, "wr_turn");
    idle_check(0, "idle_turn");

    // Fill a small window with known words, upper address bits randomised
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      if (d == 32'hFFFF_FFFF) d = 32'h0;
      a = {12'($urandom), 10'd0, 8'(i)};
      write_op(0, a, d, 4'hF, 0, "fill");
    end

    // Longer wait states
    write_op(1, 30'h7, 32'h5A5A_A5A5, 4'hF, 0, "w1_wr");
    read_op(1, 30'h7, "w1_rd");
    chk("w1_rd_val", rdata[1], 32'h5A5A_A5A5);
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      if (d == 32'hFFFF_FFFF) d = 32'h0;
      a = 30'($urandom_range(0, 3));
      write_op(1, a, d, 4'($urandom), 1'($urandom), "w1_rnd_wr");
      if (known[1][a[7:0]]) read_op(1, a, "w1_rnd_rd");
    end
    idle_check(1, "idle_w1");

    // Random mix on the default controller
    for (int i = 0; i < 40; i++) begin
      a = {12'($urandom), 10'd0, 8'($urandom_range(0, 16))};
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        if (d == 32'hFFFF_FFFF) d = 32'h0;
        write_op(0, a, d, 4'($urandom), 1'($urandom), "rnd_wr");
      end else if (known[0][a[7:0]]) begin
        read_op(0, a, "rnd_rd");
      end
    end
    idle_check(0, "idle_rnd");

    // Reset asserted during the write pulse
    addr[0] = 30'h55; wdata[0] = 32'h1234_5678; be[0] = 4'hF; we[0] = 1'b1;
    @(negedge clk);                       // WSETUP
    @(negedge clk);                       // WPULSE
    chk("rstw_pre_we", we_n[0], 0);
    rst_n = 1'b0;
    #1;
    chk("rstw_we",    we_n[0], 1);
    chk("rstw_ce",    ce_n[0], 1);
    chk("rstw_lanes", {lb_n[0], ub_n[0]}, 4'hF);
    chk("rstw_dq",    dq_obs[0], 32'hFFFF_FFFF);
    we[0] = 1'b0;
    known[0][8'h55] = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstw_noready", ready[0], 0);
    end
    rst_n = 1'b1;
    last_rd[0] = '0;
    @(negedge clk);
    chk("rstw_busy",  busy[0], 0);
    chk("rstw_rdata", rdata[0], 0);
    write_op(0, 30'h8, 32'h7654_3210, 4'hF, 0, "post_wr");
    read_op(0, 30'h8, "post_rd");
    chk("post_rd_val", rdata[0], 32'h7654_3210);
    idle_check(0, "idle_end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_ctrl.md
# sram_ctrl

Memory-side controller between the `cpu` memory port and the two IS61LV25616 256K×16 asynchronous SRAMs that together form the 32-bit main memory. It accepts one word read or write at a time over a ready handshake and sequences chip-enable, output-enable, write-enable and byte-lane strobes with programmable wait states. It owns the bidirectional SRAM data bus, so that bus is only driven during write data phases.

## Interface
- `AWIDTH`, 18: SRAM word-address width; `cpu_addr[AWIDTH-1:0]` is used, upper bits are ignored.
- `RD_WAIT`, 2: cycles `sram_oe_n` is held low before read data is sampled; legal range 1..15.
- `WR_WAIT`, 1: cycles `sram_we_n` is held low; legal range 1..15.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cpu_re` in 1: read request, held until `cpu_ready`.
- `cpu_we` in 1: write request, held until `cpu_ready`; wins if `cpu_re` is also high.
- `cpu_addr` in 30: word address.
- `cpu_wdata` in 32: write data.
- `cpu_be` in 4: byte enables for writes; bit0 = [7:0], bit3 = [31:24].
- `cpu_rdata` out 32: registered read data, valid when `cpu_ready` is high after a read.
- `cpu_ready` out 1: one-cycle completion pulse.
- `busy` out 1: high in any non-IDLE state.
- `sram_addr` out AWIDTH: address to both chips.
- `sram_dq` inout 32: [15:0] to the low chip, [31:16] to the high chip.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n` out 1 each: shared by both chips, active-low.
- `sram_lb_n`, `sram_ub_n` out 2 each: index 0 is the low chip, index 1 the high chip.

## Operation
- States: IDLE, READ, WSETUP, WPULSE, WHOLD, DONE. A 4-bit wait counter serves READ and WPULSE.
- **IDLE**
  - Requests are sampled only here.
  - On `cpu_we`: latch addr, wdata and be, go to WSETUP.
  - Else on `cpu_re`: latch addr, go to READ.
- **READ**
  - `ce_n`=0, `oe_n`=0, all lane strobes 0.
  - Stays RD_WAIT cycles.
  - On the edge leaving the last READ cycle, `sram_dq` is captured into `cpu_rdata`.
- **WSETUP**, 1 cycle: `ce_n`=0, `we_n`=1, dq driven with latched wdata, lanes applied.
- **WPULSE**, WR_WAIT cycles: `we_n`=0.
- **WHOLD**, 1 cycle: `we_n`=1, data still driven.
- **DONE**, 1 cycle: `cpu_ready`=1, all strobes deasserted, dq released. Always returns to IDLE.
- Lane mapping: `be[0]`→`lb_n[0]`, `be[1]`→`ub_n[0]`, `be[2]`→`lb_n[1]`, `be[3]`→`ub_n[1]` (strobe = ~be).
- Write with `cpu_be`=0: the full sequence runs with all lanes high, so no byte changes, and `cpu_ready` still pulses.
- `cpu_rdata` holds its last read value across writes.
- The CPU must drop its request in the cycle after `cpu_ready`. A request still high in the following IDLE cycle is treated as a new transaction.

## Timing
- Reset values: `ce_n`/`oe_n`/`we_n`/`lb_n`/`ub_n` all 1, `sram_addr`=0, dq high-Z, `cpu_ready`=0, `cpu_rdata`=0, `busy`=0, state IDLE.
- All SRAM control outputs are registered, with no combinational path from `cpu_*`.
- Read latency (cycle 0 = IDLE sees `cpu_re`): READ in cycles 1..RD_WAIT, `cpu_ready` in cycle RD_WAIT+1. Default: ready in cycle 3.
- Write latency: WSETUP cycle 1, WPULSE cycles 2..WR_WAIT+1, WHOLD cycle WR_WAIT+2, `cpu_ready` in cycle WR_WAIT+3. Default: ready in cycle 4.
- Back-to-back throughput: one transaction per latency+1 cycles, because an IDLE cycle is always inserted.
- Bus turnaround: after a read, `oe_n` rises at DONE and dq is first driven at WSETUP, two cycles later. No extra turnaround state is needed.
- `sram_addr`, dq and lane strobes are stable throughout WSETUP..WHOLD, so address and data setup/hold around the `we_n` low pulse is at least one cycle each side.
- `rst_n` asserted mid-transaction:
  - all strobes go high and dq goes high-Z immediately (asynchronously);
  - no `cpu_ready` is issued;
  - a partially completed write leaves that SRAM word undefined.

## Structure
- Package `sram_pkg` holds:
  - the state enum;
  - default `RD_WAIT`/`WR_WAIT`;
  - the 4-bit wait-counter width.
- Single module, no sub-module. The tristate lives in `sram_ctrl`: `sram_dq = drive ? wdata_q : 'z`, with `drive` registered high in WSETUP, WPULSE and WHOLD.

## Test plan
- Write 0xDEADBEEF to addr 0x00010 with be=4'hF, then read it back → `cpu_rdata`=0xDEADBEEF, write ready in cycle 4, read ready in cycle 3.
- Write be=4'b0100 with data 0x00AB0000 over the stored 0x11223344 → read returns 0x11AB3344; only `lb_n[1]` is low during WPULSE.
- `cpu_re` and `cpu_we` high together → a write is performed, `oe_n` never goes low.
- Read immediately followed by a write → at least two cycles between `oe_n` rising and dq leaving high-Z; a checker flags any cycle with `oe_n`=0 while dq is driven.
- `RD_WAIT`=4, `WR_WAIT`=3 → read ready in cycle 5, write ready in cycle 6; `we_n` low for exactly 3 cycles.
- `rst_n` pulsed low during WPULSE → `we_n`=1, dq=Z in the same timestep; no `cpu_ready`; the next request after release completes normally.
